// File: rtl/batman_sprite_fetch.sv
// batman_sprite_fetch: read-side engine for the ten Batman pose ROMs.
// Maps DrawX/DrawY into a shared ROM address, selects the pose ROM,
// applies flip and transparency, and emits a 3-cycle pixel pipeline.
// It also runs the idle-breathing animation (STAND <-> STAND2).
// Optional feature macro: SPRITE_MIRROR_EN. When it is defined, facing_left
// is latched and columns are mirrored. When it is undefined, facing_left is ignored.
module batman_sprite_fetch #(
    parameter int SPRITE_W        = 64,
    parameter int SPRITE_H        = 64,
    parameter int TRANSPARENT_IDX = 0,
    parameter int IDLE_FRAMES     = 30
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        frame_start,
    input  logic [3:0]  pose_in,
    input  logic [9:0]  sprite_x,
    input  logic [9:0]  sprite_y,
    input  logic        facing_left,
    input  logic [9:0]  draw_x,
    input  logic [9:0]  draw_y,
    input  logic        pix_valid_in,
    output logic [11:0] rom_addr,
    input  logic [39:0] rom_q,
    output logic [3:0]  pix_index,
    output logic        pix_opaque,
    output logic        pix_valid_out
);

    localparam int CW = $clog2(SPRITE_W);

    localparam logic [3:0] POSE_STAND = 4'd0;
    localparam logic [3:0] POSE_MOVE  = 4'd8;
    localparam logic [3:0] ROM_STAND  = 4'd0;
    localparam logic [3:0] ROM_STAND2 = 4'd8;
    localparam logic [3:0] ROM_MOVE   = 4'd9;

    typedef enum logic {IDLE_A, IDLE_B} idle_state_t;

    // Frame-latched sprite attributes. These stay stable for the whole frame.
    logic [3:0] lat_pose;
    logic [9:0] lat_sx;
    logic [9:0] lat_sy;
    logic       flip;

    idle_state_t state_q, state_d;
    logic [7:0]  count_q, count_d;

    logic [3:0]  rom_sel;
    logic [10:0] x_ext, y_ext, sx_ext, sy_ext;
    logic [10:0] col_off, row_off, col_sel;
    logic [11:0] addr_next;
    logic        in_box;

    logic        valid1, in_box1, valid2, in_box2;
    logic [3:0]  rom_sel1, rom_sel2;
    logic [3:0]  q_sel;
    logic        hit2;

    // Capture pose and position on frame_start. Pose codes above MOVE fold to STAND.
    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            lat_pose <= POSE_STAND;
            lat_sx   <= '0;
            lat_sy   <= '0;
        end else if (frame_start) begin
            lat_pose <= (pose_in > POSE_MOVE) ? POSE_STAND : pose_in;
            lat_sx   <= sprite_x;
            lat_sy   <= sprite_y;
        end
    end

`ifdef SPRITE_MIRROR_EN
    logic lat_flip;

    // Facing direction is latched together with the other frame attributes.
    always_ff @(posedge clock) begin
        if (!reset_n)         lat_flip <= 1'b0;
        else if (frame_start) lat_flip <= facing_left;
    end

    assign flip = lat_flip;
`else
    logic unused_facing;
    assign unused_facing = facing_left;
    assign flip          = 1'b0;
`endif

    // Idle FSM state register.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= IDLE_A;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // Idle FSM next state. The pose checked is the one latched for the frame that is ending.
    // NOTE: defaults are assigned first so every path drives every output and no latch is inferred.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        if (frame_start) begin
            if (lat_pose != POSE_STAND) begin
                state_d = IDLE_A;
                count_d = '0;
            end else if (count_q == 8'(IDLE_FRAMES - 1)) begin
                state_d = (state_q == IDLE_A) ? IDLE_B : IDLE_A;
                count_d = '0;
            end else begin
                count_d = count_q + 8'd1;
            end
        end
    end

    // Pick which ROM serves the latched pose.
    always_comb begin
        rom_sel = lat_pose;
        if (lat_pose == POSE_STAND)
            rom_sel = (state_q == IDLE_B) ? ROM_STAND2 : ROM_STAND;
        else if (lat_pose == POSE_MOVE)
            rom_sel = ROM_MOVE;
    end

    // Box test and address. Sums are 11 bits wide, so the box clips at the
    // screen edge instead of wrapping. Inside the box col < SPRITE_W, so
    // row*SPRITE_W + col reduces to a shift and an OR.
    always_comb begin
        x_ext     = {1'b0, draw_x};
        y_ext     = {1'b0, draw_y};
        sx_ext    = {1'b0, lat_sx};
        sy_ext    = {1'b0, lat_sy};
        in_box    = (x_ext >= sx_ext) && (x_ext < sx_ext + 11'(SPRITE_W)) &&
                    (y_ext >= sy_ext) && (y_ext < sy_ext + 11'(SPRITE_H));
        col_off   = x_ext - sx_ext;
        row_off   = y_ext - sy_ext;
        col_sel   = flip ? (11'(SPRITE_W - 1) - col_off) : col_off;
        addr_next = ({1'b0, row_off} << CW) | {1'b0, col_sel};
    end

    // S1: register the ROM address. It holds when the pixel is invalid or outside the box.
    // NOTE: every pipeline flop is reset so no pre-reset pixel can emerge afterwards.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            rom_addr <= '0;
            valid1   <= 1'b0;
            in_box1  <= 1'b0;
            rom_sel1 <= '0;
        end else begin
            valid1   <= pix_valid_in;
            in_box1  <= in_box;
            rom_sel1 <= rom_sel;
            if (pix_valid_in && in_box)
                rom_addr <= addr_next;
        end
    end

    // S2: delay the side-band signals while the ROM performs its registered read.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            valid2   <= 1'b0;
            in_box2  <= 1'b0;
            rom_sel2 <= '0;
        end else begin
            valid2   <= valid1;
            in_box2  <= in_box1;
            rom_sel2 <= rom_sel1;
        end
    end

    assign q_sel = rom_q[{rom_sel2, 2'b00} +: 4];
    assign hit2  = valid2 & in_box2;

    // S3: register the outputs. Transparent or off-box pixels are not opaque.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            pix_index     <= '0;
            pix_opaque    <= 1'b0;
            pix_valid_out <= 1'b0;
        end else begin
            pix_index     <= hit2 ? q_sel : 4'd0;
            pix_opaque    <= hit2 && (q_sel != 4'(TRANSPARENT_IDX));
            pix_valid_out <= valid2;
        end
    end

endmodule
